hci_tcdm_sram_responder: RTL and testbench

- TCDM slave-side responder: terminates one TCDM initiator port (req/gnt, r_valid/r_data) onto a local byte-enabled word memory.
- Serves as a bank endpoint behind the HWPE reorder/interconnect layers; usable as a synthesizable scratch bank or as the bank model in interconnect testbenches.
- Configurable read latency, optional write responses and pseudo-random grant stalling to exercise initiator backpressure.

---
 rtl/hci_tcdm_sram_responder.sv | 110 +++++++++++
 tb/tb_hci_tcdm_sram_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_tcdm_sram_responder.sv
// TCDM bank endpoint: terminates one req/gnt + r_valid/r_data initiator port on a
// byte-enabled word memory with configurable latency and optional grant stalling.
module hci_tcdm_sram_responder #(
  parameter int unsigned NB_WORDS     = 1024,
  parameter int unsigned LATENCY      = 1,
  parameter bit          WRITE_RESP   = 1'b1,
  parameter bit          STALL_EN     = 1'b0,
  parameter int unsigned STALL_THRESH = 4,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        tcdm_req_i,
  input  logic [31:0] tcdm_add_i,
  input  logic        tcdm_wen_i,
  input  logic [3:0]  tcdm_be_i,
  input  logic [31:0] tcdm_data_i,
  output logic        tcdm_gnt_o,
  output logic [31:0] tcdm_r_data_o,
  output logic        tcdm_r_valid_o,
  output logic        err_o,
  output logic [31:0] nb_rd_o,
  output logic [31:0] nb_wr_o
);

  localparam int unsigned IDX_W = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

  logic [31:0]      mem [NB_WORDS];
  logic [15:0]      lfsr_q;
  logic [29:0]      word_idx;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             stall;
  logic             hs;
  logic             rd_hs;
  logic             wr_hs;
  logic             resp_v;
  logic [31:0]      resp_d;
  logic [31:0]      rd_word;
  logic             unused_addr;

  logic [LATENCY-1:0] pv_q;
  logic [31:0]        pd_q [LATENCY];

  assign word_idx    = tcdm_add_i[31:2];
  assign idx         = word_idx[IDX_W-1:0];
  assign in_range    = word_idx < 30'(NB_WORDS);
  assign unused_addr = ^tcdm_add_i[1:0];

  // Grant is combinational; reset and clear both block new handshakes.
  assign stall      = STALL_EN && ({1'b0, lfsr_q[3:0]} < 5'(STALL_THRESH));
  assign tcdm_gnt_o = tcdm_req_i & ~stall & ~rst_i & ~clear_i;

  assign hs     = tcdm_gnt_o;
  assign rd_hs  = hs & tcdm_wen_i;
  assign wr_hs  = hs & ~tcdm_wen_i;

  assign rd_word = in_range ? mem[idx] : ERR_DATA;
  assign resp_v  = rd_hs | (wr_hs & WRITE_RESP);
  assign resp_d  = rd_hs ? rd_word : 32'h0;

  // Word memory with byte enables; out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NB_WORDS; i++) mem[i] <= '0;
    end else if (wr_hs && in_range) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (tcdm_be_i[k]) mem[idx][8*k +: 8] <= tcdm_data_i[8*k +: 8];
      end
    end
  end

  // Response pipeline; data stages only move with a valid so r_data holds between pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pd_q[i] <= '0;
    end else if (clear_i) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= resp_v;
      if (resp_v) pd_q[0] <= resp_d;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign tcdm_r_valid_o = pv_q[LATENCY-1];
  assign tcdm_r_data_o  = pd_q[LATENCY-1];

  // Stall LFSR (taps 16,14,13,11), error flag and handshake counters.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lfsr_q  <= SEED;
      err_o   <= 1'b0;
      nb_rd_o <= '0;
      nb_wr_o <= '0;
    end else begin
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      err_o   <= err_o | (hs & ~in_range);
      nb_rd_o <= nb_rd_o + 32'(rd_hs);
      nb_wr_o <= nb_wr_o + 32'(wr_hs);
    end
  end

endmodule

// File: tb/tb_hci_tcdm_sram_responder.sv
// Bench: four responder configurations on one clock, checked cycle by cycle
// against a transaction-level model (word array + due-cycle response schedule).
module tb_hci_tcdm_sram_responder;

  function automatic int unsigned lat_f(input int g);
    case (g)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 4;
    endcase
  endfunction
  function automatic bit wresp_f(input int g);
    return g != 3;
  endfunction
  function automatic bit stall_f(input int g);
    return g == 2;
  endfunction
  function automatic int unsigned nbw_f(input int g);
    return (g == 2) ? 600 : 1024;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] add = '0;
  logic        wen = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [3:0]  rv;
  logic [3:0]  err;
  logic [31:0] rd  [4];
  logic [31:0] nrd [4];
  logic [31:0] nwr [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    hci_tcdm_sram_responder #(
      .NB_WORDS     (nbw_f(g)),
      .LATENCY      (lat_f(g)),
      .WRITE_RESP   (wresp_f(g)),
      .STALL_EN     (stall_f(g)),
      .STALL_THRESH (8),
      .SEED         (16'hACE1),
      .ERR_DATA     (32'hDEADBEEF)
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .clear_i        (clr),
      .tcdm_req_i     (req[g]),
      .tcdm_add_i     (add),
      .tcdm_wen_i     (wen),
      .tcdm_be_i      (be),
      .tcdm_data_i    (wdata),
      .tcdm_gnt_o     (gnt[g]),
      .tcdm_r_data_o  (rd[g]),
      .tcdm_r_valid_o (rv[g]),
      .err_o          (err[g]),
      .nb_rd_o        (nrd[g]),
      .nb_wr_o        (nwr[g])
    );
  end

  // Reference model state
  logic [31:0] mm [4][1024];
  logic [15:0] ml [4];
  logic [31:0] mrd [4];
  logic [31:0] mwr [4];
  logic        merr [4];
  logic [31:0] mhold [4];
  logic        sv [4][16];
  logic [31:0] sd [4][16];
  logic [31:0] last_rd [4];
  bit   [3:0]  hs_m;
  int          cyc = 0;
  int          run1 = 0;
  int          max_run1 = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(input int i, input bit full);
    if (full) begin
      for (int a = 0; a < 1024; a++) mm[i][a] = '0;
      mhold[i] = '0;
    end
    ml[i] = 16'hACE1;
    mrd[i] = '0;
    mwr[i] = '0;
    merr[i] = 1'b0;
    for (int s = 0; s < 16; s++) sv[i][s] = 1'b0;
  endtask

  // One clock cycle: inputs already driven; check grant, advance model, check outputs.
  task automatic tick();
    bit          stl;
    bit          eg;
    bit          inr;
    int unsigned w;
    int          s;
    #1;
    for (int i = 0; i < 4; i++) begin
      stl = stall_f(i) && (ml[i][3:0] < 4'd8);
      eg  = req[i] && !rst && !clr && !stl;
      chk($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(eg));
      hs_m[i] = eg;
    end
    for (int i = 0; i < 4; i++) begin
      if (rst) model_reset(i, 1'b1);
      else if (clr) model_reset(i, 1'b0);
      else begin
        if (hs_m[i]) begin
          w   = add >> 2;
          inr = w < nbw_f(i);
          s   = (cyc + int'(lat_f(i))) % 16;
          if (wen) begin
            sv[i][s] = 1'b1;
            sd[i][s] = inr ? mm[i][w] : 32'hDEADBEEF;
            mrd[i]++;
          end else begin
            if (inr) for (int k = 0; k < 4; k++) if (be[k]) mm[i][w][8*k +: 8] = wdata[8*k +: 8];
            if (wresp_f(i)) begin
              sv[i][s] = 1'b1;
              sd[i][s] = '0;
            end
            mwr[i]++;
          end
          if (!inr) merr[i] = 1'b1;
        end
        ml[i] = {ml[i][14:0], ^(ml[i] & 16'hB400)};
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    s = cyc % 16;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rvalid%0d", i), 32'(rv[i]), 32'(sv[i][s]));
      if (sv[i][s]) mhold[i] = sd[i][s];
      sv[i][s] = 1'b0;
      chk($sformatf("rdata%0d", i), rd[i], mhold[i]);
      if (rv[i]) last_rd[i] = rd[i];
      chk($sformatf("nb_rd%0d", i), nrd[i], mrd[i]);
      chk($sformatf("nb_wr%0d", i), nwr[i], mwr[i]);
      chk($sformatf("err%0d", i), 32'(err[i]), 32'(merr[i]));
    end
    if (rv[1]) begin
      run1++;
      if (run1 > max_run1) max_run1 = run1;
    end else run1 = 0;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) tick();
  endtask

  task automatic acc(input int i, input bit w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    req = '0;
    req[i] = 1'b1;
    wen = w;
    add = a;
    be = b;
    wdata = d;
    tick();
    req = '0;
  endtask

  int nhs;
  int nlow;
  int ncyc;
  bit fresh;

  initial begin
    // Reset with a pending request: grant must stay low
    rst = 1'b1;
    req[0] = 1'b1;
    wen = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle(1);

    // Zero-wait write then read (LATENCY=1)
    acc(0, 1'b0, 32'h10, 4'hF, 32'hCAFEF00D);
    acc(0, 1'b1, 32'h10, 4'h0, 32'h0);
    idle(2);
    chk("wr_rd_data", last_rd[0], 32'hCAFEF00D);
    chk("wr_rd_nb_wr", nwr[0], 32'd1);
    chk("wr_rd_nb_rd", nrd[0], 32'd1);

    // Byte enables
    acc(0, 1'b0, 32'h20, 4'hF, 32'h11223344);
    acc(0, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD);
    acc(0, 1'b1, 32'h20, 4'h0, 32'h0);
    idle(2);
    chk("byte_en", last_rd[0], 32'h11BB33DD);

    // LATENCY=3 streaming of 8 back-to-back reads
    for (int k = 0; k < 8; k++) acc(1, 1'b0, 32'(k * 4), 4'hF, 32'hA0000000 | 32'(k));
    idle(4);
    max_run1 = 0;
    run1 = 0;
    for (int k = 0; k < 8; k++) acc(1, 1'b1, 32'(k * 4), 4'h0, 32'h0);
    idle(5);
    chk("stream_run", 32'(max_run1), 32'd8);
    chk("stream_last", last_rd[1], 32'hA0000007);

    // Randomized accesses against a stalling bank (threshold 8, 600 words)
    nhs = 0;
    nlow = 0;
    ncyc = 0;
    fresh = 1'b1;
    while (nhs < 200 && ncyc < 3000) begin
      if (fresh) begin
        wen = 1'($urandom_range(0, 1));
        add = 32'($urandom_range(0, 639)) << 2;
        be = 4'($urandom);
        wdata = $urandom;
      end
      req = 4'b0100;
      tick();
      ncyc++;
      if (!gnt[2]) nlow++;
      fresh = hs_m[2];
      if (hs_m[2]) nhs++;
    end
    idle(4);
    chk("rand_hs_count", 32'(nhs), 32'd200);
    chk("rand_gnt_low_ratio", 32'((nlow * 4 >= ncyc) && (nlow * 4 <= ncyc * 3)), 32'd1);

    // No write response, out-of-range read, sticky error
    acc(3, 1'b0, 32'h14, 4'hF, 32'h5A5A1234);
    idle(5);
    acc(3, 1'b1, 32'h1000, 4'h0, 32'h0);
    idle(5);
    chk("oor_data", last_rd[3], 32'hDEADBEEF);
    chk("oor_err", 32'(err[3]), 32'd1);
    acc(3, 1'b0, 32'h40, 4'hF, 32'h12345678);
    idle(5);

    // Clear two cycles after the last of three reads; request during clear not granted
    for (int k = 0; k < 3; k++) acc(3, 1'b1, 32'h14, 4'h0, 32'h0);
    idle(1);
    clr = 1'b1;
    req[0] = 1'b1;
    wen = 1'b1;
    tick();
    clr = 1'b0;
    idle(6);
    chk("clr_nb_rd", nrd[3], 32'd0);
    chk("clr_nb_wr", nwr[3], 32'd0);
    chk("clr_err", 32'(err[3]), 32'd0);
    acc(3, 1'b1, 32'h14, 4'h0, 32'h0);
    idle(5);
    chk("clr_mem_kept", last_rd[3], 32'h5A5A1234);

    // Mid-operation reset with clear also high: pending read dropped, memory zeroed
    acc(3, 1'b1, 32'h14, 4'h0, 32'h0);
    rst = 1'b1;
    clr = 1'b1;
    tick();
    rst = 1'b0;
    clr = 1'b0;
    idle(6);
    acc(3, 1'b1, 32'h14, 4'h0, 32'h0);
    idle(5);
    chk("rst_mem_zero", last_rd[3], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
